keypad_scanner: RTL

//  Scans a 4x4 matrix keypad (input side of the calculator front panel) by

---
 rtl/keypad_scanner.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x4 matrix keypad scanner with press/release debounce and a
//            valid/ready key-code output (one code per press, no repeat).
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_enable,
  input  logic [3:0] kp_row_n,
  output logic [3:0] kp_col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_overrun
);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;

  localparam logic [7:0] c_deb_scans = 8'(DEBOUNCE_SCANS);

  logic [3:0] rows_meta_q, rows_s_q;
  logic [1:0] state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [1:0] row_q, row_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] key_code_q;
  logic       key_valid_q;
  logic       key_overrun_q;

  logic [1:0] w_low_row;
  logic [7:0] w_cnt_inc;
  logic       w_accept;

  // Two-flop synchronizer for the asynchronous row lines (idle = pulled high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_meta_q <= 4'b1111;
      rows_s_q    <= 4'b1111;
    end else begin
      rows_meta_q <= kp_row_n;
      rows_s_q    <= rows_meta_q;
    end
  end

  // Lowest-index active row wins when several keys share the scanned column
  always_comb begin
    w_low_row = 2'd3;
    if      (!rows_s_q[0]) w_low_row = 2'd0;
    else if (!rows_s_q[1]) w_low_row = 2'd1;
    else if (!rows_s_q[2]) w_low_row = 2'd2;
  end

  assign w_cnt_inc = cnt_q + 8'd1;

  // Scan / debounce / hold sequencing; only advances on the scan strobe
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    w_accept = 1'b0;
    if (clk_enable) begin
      case (state_q)
        S_SCAN: begin
          if (rows_s_q == 4'b1111) begin
            col_d = col_q + 2'd1;
          end else begin
            row_d = w_low_row;
            if (c_deb_scans == 8'd1) begin
              w_accept = 1'b1;
              cnt_d    = 8'd0;
              state_d  = S_HELD;
            end else begin
              cnt_d   = 8'd1;
              state_d = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (!rows_s_q[row_q]) begin
            if (w_cnt_inc == c_deb_scans) begin
              w_accept = 1'b1;
              cnt_d    = 8'd0;
              state_d  = S_HELD;
            end else begin
              cnt_d = w_cnt_inc;
            end
          end else begin
            // Bounce: abandon this key and resume scanning at the next column
            cnt_d   = 8'd0;
            col_d   = col_q + 2'd1;
            state_d = S_SCAN;
          end
        end
        S_HELD: begin
          if (rows_s_q == 4'b1111) begin
            if (w_cnt_inc == c_deb_scans) begin
              cnt_d   = 8'd0;
              col_d   = col_q + 2'd1;
              state_d = S_SCAN;
            end else begin
              cnt_d = w_cnt_inc;
            end
          end else begin
            cnt_d = 8'd0;
          end
        end
        default: begin
          cnt_d   = 8'd0;
          state_d = S_SCAN;
        end
      endcase
    end
  end

  // Scan state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output holding register: load on accept if free (or being drained), else flag overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_overrun_q <= 1'b0;
    end else begin
      key_overrun_q <= 1'b0;
      if (w_accept) begin
        if (!key_valid_q || key_ready) begin
          key_code_q  <= {row_d, col_q};
          key_valid_q <= 1'b1;
        end else begin
          key_overrun_q <= 1'b1;
        end
      end else if (key_valid_q && key_ready) begin
        key_valid_q <= 1'b0;
      end
    end
  end

  assign kp_col_n    = ~(4'b0001 << col_q);
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_overrun = key_overrun_q;

endmodule
`default_nettype wire
